// File: rtl/input_conditioner_if.sv
// Switch/key conditioning bus: raw inputs in, debounced levels and edge pulses out.
// The master drives raw_in (board side); the slave is the conditioner itself.
interface input_conditioner_if #(
  parameter int N_CH = 2
);
  logic [N_CH-1:0] raw_in;
  logic [N_CH-1:0] clean_lvl;
  logic [N_CH-1:0] rise_pls;
  logic [N_CH-1:0] fall_pls;

  modport master (
    output raw_in,
    input  clean_lvl,
    input  rise_pls,
    input  fall_pls
  );

  modport slave (
    input  raw_in,
    output clean_lvl,
    output rise_pls,
    output fall_pls
  );
endinterface

// File: rtl/input_conditioner.sv
// Per-channel two-flop synchroniser, saturating debounce counter and 4-state FSM
// producing a clean level plus registered one-cycle rise/fall pulses.
module input_conditioner #(
  parameter int N_CH            = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic                CLK_50MHz,
  input  logic                rst_n,
  input_conditioner_if.slave  bus,
  output logic [2*N_CH-1:0]   state_dbg_o
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_MAX  = {CW{1'b1}};

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'd0,
    LOW_CHK     = 2'd1,
    HIGH_STABLE = 2'd2,
    HIGH_CHK    = 2'd3
  } state_e;

  logic [N_CH-1:0] raw_pol;
  logic [N_CH-1:0] s1_q;
  logic [N_CH-1:0] s2_q;
  logic [N_CH-1:0] lvl_w;
  logic [N_CH-1:0] rise_w;
  logic [N_CH-1:0] fall_w;

  assign raw_pol = (ACTIVE_LOW != 0) ? ~bus.raw_in : bus.raw_in;

  always_ff @(posedge CLK_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw_pol;
      s2_q <= s1_q;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          lvl_q;
    logic          rise_q;
    logic          fall_q;

    // Pulses default low every cycle so an accept yields exactly one cycle high.
    always_ff @(posedge CLK_50MHz or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= LOW_STABLE;
        cnt_q   <= '0;
        lvl_q   <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        case (state_q)
          LOW_STABLE: begin
            if (s2_q[g]) begin
              state_q <= LOW_CHK;
              cnt_q   <= CW'(1);
            end else begin
              cnt_q   <= '0;
            end
          end
          LOW_CHK: begin
            if (!s2_q[g]) begin
              state_q <= LOW_STABLE;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= HIGH_STABLE;
              cnt_q   <= '0;
              lvl_q   <= 1'b1;
              rise_q  <= 1'b1;
            end else if (cnt_q != CNT_MAX) begin
              cnt_q   <= cnt_q + CW'(1);
            end
          end
          HIGH_STABLE: begin
            if (!s2_q[g]) begin
              state_q <= HIGH_CHK;
              cnt_q   <= CW'(1);
            end else begin
              cnt_q   <= '0;
            end
          end
          HIGH_CHK: begin
            if (s2_q[g]) begin
              state_q <= HIGH_STABLE;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= LOW_STABLE;
              cnt_q   <= '0;
              lvl_q   <= 1'b0;
              fall_q  <= 1'b1;
            end else if (cnt_q != CNT_MAX) begin
              cnt_q   <= cnt_q + CW'(1);
            end
          end
          default: begin
            state_q <= LOW_STABLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    assign lvl_w[g]              = lvl_q;
    assign rise_w[g]             = rise_q;
    assign fall_w[g]             = fall_q;
    assign state_dbg_o[2*g +: 2] = state_q;
  end

  assign bus.clean_lvl = lvl_w;
  assign bus.rise_pls  = rise_w;
  assign bus.fall_pls  = fall_w;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=8: latency, bounce,
// glitch, simultaneous channels and reset mid-count, plus per-cycle pulse checks.
module tb_input_conditioner;

  localparam int N_CH  = 2;
  localparam int DEB   = 8;
  localparam int LAT   = DEB + 2;
  localparam int LIMIT = 40;

  logic              clk;
  logic              rst_n;
  logic [2*N_CH-1:0] state_dbg;

  int n_assert = 0;
  int n_fail   = 0;

  input_conditioner_if #(.N_CH(N_CH)) bus ();

  input_conditioner #(
    .N_CH            (N_CH),
    .DEBOUNCE_CYCLES (DEB),
    .ACTIVE_LOW      (0)
  ) dut (
    .CLK_50MHz   (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .state_dbg_o (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Counts clocks until the selected pulse appears; LIMIT means it never came.
  task automatic wait_pulse(input string tag, input int ch, input bit is_rise,
                            input int exp_clk);
    int  n;
    bit  seen;
    n    = LIMIT;
    seen = 1'b0;
    for (int i = 1; i <= LIMIT && !seen; i++) begin
      step(1);
      if ((is_rise ? bus.rise_pls[ch] : bus.fall_pls[ch]) === 1'b1) begin
        n    = i;
        seen = 1'b1;
      end
    end
    check(tag, n, exp_clk);
  endtask

  // Steps n clocks and returns whether any pulse was seen on any channel.
  task automatic quiet(input int n, output bit any);
    any = 1'b0;
    repeat (n) begin
      step(1);
      if ((bus.rise_pls | bus.fall_pls) !== '0) any = 1'b1;
    end
  endtask

  logic [N_CH-1:0] prev_rise;
  logic [N_CH-1:0] prev_fall;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("rise_fall_overlap", {30'd0, bus.rise_pls & bus.fall_pls}, 32'd0);
      check("pulse_width", {28'd0, bus.rise_pls & prev_rise, bus.fall_pls & prev_fall}, 32'd0);
      prev_rise = bus.rise_pls;
      prev_fall = bus.fall_pls;
    end else begin
      prev_rise = '0;
      prev_fall = '0;
    end
  end

  initial begin
    bit any;
    rst_n      = 1'b0;
    bus.raw_in = 2'b11;
    step(4);

    // Reset with inputs held high
    check("rst_clean", bus.clean_lvl, 2'b00);
    check("rst_rise",  bus.rise_pls,  2'b00);
    check("rst_fall",  bus.fall_pls,  2'b00);
    check("rst_state", state_dbg,     4'b0000);
    rst_n = 1'b1;
    wait_pulse("rel_rise_lat", 0, 1'b1, LAT);
    check("rel_rise_both", bus.rise_pls, 2'b11);
    check("rel_clean",     bus.clean_lvl, 2'b11);
    step(1);
    check("rel_rise_gone", bus.rise_pls, 2'b00);
    check("rel_clean_hold", bus.clean_lvl, 2'b11);
    bus.raw_in = 2'b00;
    wait_pulse("rel_fall_lat", 1, 1'b0, LAT);
    check("rel_fall_both", bus.fall_pls, 2'b11);
    step(3);

    // Clean step on ch0
    bus.raw_in = 2'b01;
    wait_pulse("step_rise_lat", 0, 1'b1, LAT);
    check("step_rise_val", bus.rise_pls, 2'b01);
    check("step_clean_up", bus.clean_lvl, 2'b01);
    step(1);
    check("step_rise_1cyc", bus.rise_pls, 2'b00);
    step(3);
    bus.raw_in = 2'b00;
    wait_pulse("step_fall_lat", 0, 1'b0, LAT);
    check("step_fall_val", bus.fall_pls, 2'b01);
    check("step_clean_dn", bus.clean_lvl, 2'b00);
    step(3);

    // Bounce on ch0: 13 toggles, 3 clocks apart, ending high
    any = 1'b0;
    for (int i = 0; i < 13; i++) begin
      bit q;
      bus.raw_in[0] = ~bus.raw_in[0];
      if (i < 12) begin
        quiet(3, q);
        any |= q;
      end
    end
    check("bounce_no_pulse", {31'd0, any}, 32'd0);
    check("bounce_clean", bus.clean_lvl, 2'b00);
    wait_pulse("bounce_rise_lat", 0, 1'b1, LAT);
    bus.raw_in[0] = 1'b0;
    wait_pulse("bounce_fall_lat", 0, 1'b0, LAT);
    step(3);

    // Glitch on ch1: one cycle short of acceptance
    bus.raw_in[1] = 1'b1;
    step(7);
    bus.raw_in[1] = 1'b0;
    quiet(20, any);
    check("glitch_no_pulse", {31'd0, any}, 32'd0);
    check("glitch_clean", bus.clean_lvl, 2'b00);

    // Simultaneous rise, then ch0 alone falls
    bus.raw_in = 2'b11;
    wait_pulse("sim_rise_lat", 0, 1'b1, LAT);
    check("sim_rise_val", bus.rise_pls, 2'b11);
    step(3);
    bus.raw_in = 2'b10;
    wait_pulse("sim_fall_lat", 0, 1'b0, LAT);
    check("sim_fall_val", bus.fall_pls, 2'b01);
    check("sim_clean",    bus.clean_lvl, 2'b10);
    bus.raw_in = 2'b00;
    wait_pulse("sim_ch1_fall", 1, 1'b0, LAT);
    step(3);

    // Reset mid-count on ch0
    bus.raw_in[0] = 1'b1;
    quiet(5, any);
    rst_n = 1'b0;
    #1;
    check("mid_rst_clean", bus.clean_lvl, 2'b00);
    check("mid_rst_rise",  bus.rise_pls,  2'b00);
    step(3);
    check("mid_rst_hold", bus.clean_lvl | bus.rise_pls, 2'b00);
    check("mid_pre_pulse", {31'd0, any}, 32'd0);
    rst_n = 1'b1;
    wait_pulse("mid_rise_lat", 0, 1'b1, LAT);
    check("mid_rise_val", bus.rise_pls, 2'b01);
    step(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
